// File: rtl/jump_pc_sequencer.sv
// rtl/jump_pc_sequencer.sv - fetch/execute PC sequencer with jump, branch and jump-register targets
module jump_pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        imem_ack_i,
   input  logic [31:0] instr_i,
   input  logic        branch_i,
   input  logic        zero_i,
   input  logic        jump_i,
   input  logic        jr_i,
   input  logic [31:0] rs_data_i,
   output logic [31:0] pc_o,
   output logic        imem_req_o,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   output logic        busy_o,
   output logic        error_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      EXEC  = 2'b10,
      HALT  = 2'b11
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_nxt;
   logic [31:0] pc_plus4;
   logic [31:0] jump_tgt;
   logic [31:0] br_tgt;
   logic        jr_misaligned;

   assign pc_plus4      = pc_o + 32'd4;
   assign jump_tgt      = {pc_plus4[31:28], instr_o[25:0], 2'b00};
   assign br_tgt        = pc_plus4 + {{14{instr_o[15]}}, instr_o[15:0], 2'b00};
   assign jr_misaligned = jr_i && (rs_data_i[1:0] != 2'b00);

   // Outputs decode only the state register, so no input reaches them combinationally.
   assign imem_req_o    = (state == FETCH);
   assign instr_valid_o = (state == EXEC);
   assign busy_o        = (state == FETCH) || (state == EXEC);

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_o;
      case (state)
         IDLE: begin
            if (start_i) state_nxt = FETCH;
         end
         FETCH: begin
            if (imem_ack_i) state_nxt = EXEC;
         end
         EXEC: begin
            if (jr_misaligned) begin
               state_nxt = HALT;
            end else begin
               state_nxt = FETCH;
               if (jr_i)                   pc_nxt = rs_data_i;
               else if (jump_i)            pc_nxt = jump_tgt;
               else if (branch_i && zero_i) pc_nxt = br_tgt;
               else                        pc_nxt = pc_plus4;
            end
         end
         HALT: begin
            state_nxt = HALT;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state   <= IDLE;
         pc_o    <= RESET_PC;
         instr_o <= 32'h0000_0000;
         error_o <= 1'b0;
      end else begin
         state <= state_nxt;
         pc_o  <= pc_nxt;
         if (state == FETCH && imem_ack_i) instr_o <= instr_i;
         if (state == EXEC && jr_misaligned) error_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_jump_pc_sequencer.sv
// tb/tb_jump_pc_sequencer.sv - directed self-checking bench for jump_pc_sequencer
module tb_jump_pc_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        imem_ack_i;
   logic [31:0] instr_i;
   logic        branch_i;
   logic        zero_i;
   logic        jump_i;
   logic        jr_i;
   logic [31:0] rs_data_i;
   logic [31:0] pc_o;
   logic        imem_req_o;
   logic [31:0] instr_o;
   logic        instr_valid_o;
   logic        busy_o;
   logic        error_o;

   int checks = 0;
   int errors = 0;

   jump_pc_sequencer #(.RESET_PC(RST_PC)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .imem_ack_i    (imem_ack_i),
      .instr_i       (instr_i),
      .branch_i      (branch_i),
      .zero_i        (zero_i),
      .jump_i        (jump_i),
      .jr_i          (jr_i),
      .rs_data_i     (rs_data_i),
      .pc_o          (pc_o),
      .imem_req_o    (imem_req_o),
      .instr_o       (instr_o),
      .instr_valid_o (instr_valid_o),
      .busy_o        (busy_o),
      .error_o       (error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Entered in FETCH: ack one instruction, apply decode inputs during EXEC, return in next state.
   task automatic run_instr(input logic [31:0] ins, input logic br, input logic zr,
                            input logic jmp, input logic jr, input logic [31:0] rs);
      instr_i    = ins;
      imem_ack_i = 1'b1;
      step();
      imem_ack_i = 1'b0;
      branch_i   = br;
      zero_i     = zr;
      jump_i     = jmp;
      jr_i       = jr;
      rs_data_i  = rs;
      step();
      branch_i   = 1'b0;
      zero_i     = 1'b0;
      jump_i     = 1'b0;
      jr_i       = 1'b0;
      rs_data_i  = 32'h0;
   endtask

   initial begin
      rst_i = 1'b0; start_i = 1'b0; imem_ack_i = 1'b0; instr_i = 32'h0;
      branch_i = 1'b0; zero_i = 1'b0; jump_i = 1'b0; jr_i = 1'b0; rs_data_i = 32'h0;
      step(); step();
      check("rst_pc", pc_o, RST_PC);
      check("rst_req", {31'b0, imem_req_o}, 32'd0);
      check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
      check("rst_busy", {31'b0, busy_o}, 32'd0);
      check("rst_instr", instr_o, 32'h0);
      check("rst_error", {31'b0, error_o}, 32'd0);

      // No auto-start; ack in IDLE is ignored
      rst_i = 1'b1; imem_ack_i = 1'b1; instr_i = 32'hDEAD_BEEF;
      step(); step();
      imem_ack_i = 1'b0;
      check("idle_busy", {31'b0, busy_o}, 32'd0);
      check("idle_instr", instr_o, 32'h0);

      start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("fetch_req", {31'b0, imem_req_o}, 32'd1);
      check("fetch_busy", {31'b0, busy_o}, 32'd1);
      check("fetch_pc0", pc_o, 32'h0);

      // Sequential: 2 cycles per instruction
      instr_i = 32'h0; imem_ack_i = 1'b1;
      step();
      imem_ack_i = 1'b0;
      check("exec_valid", {31'b0, instr_valid_o}, 32'd1);
      check("exec_req", {31'b0, imem_req_o}, 32'd0);
      check("exec_pc", pc_o, 32'h0);
      step();
      check("seq_pc4", pc_o, 32'h4);
      check("seq_req", {31'b0, imem_req_o}, 32'd1);
      run_instr(32'h0, 0, 0, 0, 0, 32'h0);
      check("seq_pc8", pc_o, 32'h8);

      // Jump
      run_instr(32'h0, 0, 0, 0, 1, 32'h4000_0010);
      check("jr_pc", pc_o, 32'h4000_0010);
      instr_i = 32'h0800_0100; imem_ack_i = 1'b1;
      step();
      instr_i = 32'h1234_5678;
      check("jmp_instr", instr_o, 32'h0800_0100);
      jump_i = 1'b1;
      step();
      check("ack_in_exec_ignored", instr_o, 32'h0800_0100);
      imem_ack_i = 1'b0; jump_i = 1'b0;
      check("jmp_pc", pc_o, 32'h4000_0400);

      // Branch backward, taken and not taken
      run_instr(32'h0, 0, 0, 0, 1, 32'h0000_0020);
      run_instr(32'h0000_FFFE, 1, 1, 0, 0, 32'h0);
      check("br_taken", pc_o, 32'h0000_001C);
      run_instr(32'h0, 0, 0, 0, 1, 32'h0000_0020);
      run_instr(32'h0000_FFFE, 1, 0, 0, 0, 32'h0);
      check("br_not_taken", pc_o, 32'h0000_0024);

      // Priority: all decode inputs at once
      run_instr(32'h0000_FFFE, 1, 1, 1, 1, 32'h0000_0100);
      check("prio_pc", pc_o, 32'h0000_0100);
      check("prio_error", {31'b0, error_o}, 32'd0);

      // Wrap
      run_instr(32'h0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      run_instr(32'h0, 0, 0, 0, 0, 32'h0);
      check("wrap_pc", pc_o, 32'h0);

      // Decode inputs held during FETCH are ignored
      jump_i = 1'b1; jr_i = 1'b1; rs_data_i = 32'h0000_0102;
      step();
      check("fetch_decode_ignored", pc_o, 32'h0);
      check("fetch_decode_err", {31'b0, error_o}, 32'd0);
      jump_i = 1'b0; jr_i = 1'b0; rs_data_i = 32'h0;

      // Memory stall: ack after 3 cycles -> req high 4 cycles
      for (int i = 0; i < 4; i++) begin
         if (i == 3) imem_ack_i = 1'b1;
         check($sformatf("stall_req%0d", i), {31'b0, imem_req_o}, 32'd1);
         check($sformatf("stall_pc%0d", i), pc_o, 32'h0);
         step();
      end
      imem_ack_i = 1'b0;
      check("stall_exec", {31'b0, instr_valid_o}, 32'd1);
      step();
      check("stall_pc_next", pc_o, 32'h4);

      // Misaligned jr -> HALT
      run_instr(32'h0, 0, 0, 0, 1, 32'h0000_0200);
      run_instr(32'h0, 0, 0, 0, 1, 32'h0000_0102);
      check("mis_error", {31'b0, error_o}, 32'd1);
      check("mis_pc", pc_o, 32'h0000_0200);
      check("mis_busy", {31'b0, busy_o}, 32'd0);
      check("mis_req", {31'b0, imem_req_o}, 32'd0);
      start_i = 1'b1; imem_ack_i = 1'b1;
      step(); step(); step();
      start_i = 1'b0; imem_ack_i = 1'b0;
      check("halt_busy", {31'b0, busy_o}, 32'd0);
      check("halt_pc", pc_o, 32'h0000_0200);
      check("halt_error", {31'b0, error_o}, 32'd1);

      // Reset clears HALT
      rst_i = 1'b0;
      step();
      rst_i = 1'b1;
      check("halt_rst_error", {31'b0, error_o}, 32'd0);
      check("halt_rst_pc", pc_o, RST_PC);

      // Reset during FETCH with pending ack
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      run_instr(32'h0, 0, 0, 0, 1, 32'h0000_0080);
      check("pre_rst_pc", pc_o, 32'h0000_0080);
      instr_i = 32'hCAFE_F00D; imem_ack_i = 1'b1; rst_i = 1'b0;
      step();
      imem_ack_i = 1'b0; rst_i = 1'b1;
      check("frst_req", {31'b0, imem_req_o}, 32'd0);
      check("frst_busy", {31'b0, busy_o}, 32'd0);
      check("frst_pc", pc_o, RST_PC);
      check("frst_instr", instr_o, 32'h0);
      step();
      check("frst_no_autostart", {31'b0, busy_o}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jump_pc_sequencer.md
JUMP_PC_SEQUENCER -- requirements
Module: Jump_PC_Sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 The port list SHALL be:
  clk_i          input   1   clock, all state updates on rising edge
  rst_i          input   1   synchronous reset, active low
  start_i        input   1   leave IDLE and begin fetching
  imem_ack_i     input   1   instruction memory returns instr_i this cycle
  instr_i        input   32  instruction word from memory
  branch_i       input   1   decoded beq-type branch, sampled in EXEC
  zero_i         input   1   ALU zero flag, sampled in EXEC
  jump_i         input   1   decoded j-type jump, sampled in EXEC
  jr_i           input   1   decoded jump-register, sampled in EXEC
  rs_data_i      input   32  register rs value for jr
  pc_o           output  32  current PC, the fetch address
  imem_req_o     output  1   fetch request
  instr_o        output  32  captured instruction
  instr_valid_o  output  1   instr_o valid and decode inputs sampled this cycle
  busy_o         output  1   state is not IDLE or HALT
  error_o        output  1   sticky misaligned-jr flag

Function
REQ-004 States SHALL be IDLE, FETCH, EXEC and HALT, with a 2-bit encoding.
REQ-005 IDLE SHALL go to FETCH when start_i=1, and otherwise stay in IDLE.
REQ-006 In FETCH, the block SHALL:
  - hold imem_req_o=1 and keep pc_o stable;
  - on imem_ack_i=1, capture instr_i into instr_o and go to EXEC;
  - with no ack, remain in FETCH indefinitely.
REQ-007 EXEC SHALL last exactly one cycle, with instr_valid_o=1 and imem_req_o=0.
REQ-008 At the end of EXEC, the block SHALL load pc_o with next_pc and go to FETCH, except in the misaligned-jr case of REQ-012.
REQ-009 The next_pc arithmetic SHALL be modulo 2^32:
  - pc_plus4 = pc_o + 4, so 32'hFFFF_FFFC wraps to 32'h0000_0000;
  - jump_tgt = {pc_plus4[31:28], instr_o[25:0], 2'b00}, i.e. the 26-bit field shifted left two to 28 bits;
  - br_tgt = pc_plus4 + {{14{instr_o[15]}}, instr_o[15:0], 2'b00}.
REQ-010 The next_pc priority SHALL be:
  - jr_i gives rs_data_i;
  - else jump_i gives jump_tgt;
  - else (branch_i & zero_i) gives br_tgt;
  - else pc_plus4.
REQ-011 Simultaneously asserted decode inputs SHALL resolve by the REQ-010 priority only, with no error.
REQ-012 If jr_i=1 and rs_data_i[1:0]!=0 in EXEC, then:
  - pc_o SHALL stay unchanged;
  - error_o SHALL be set to 1;
  - the state SHALL go to HALT.
REQ-013 HALT SHALL be left only by reset; start_i and imem_ack_i SHALL be ignored there.
REQ-014 imem_ack_i SHALL be ignored outside FETCH, and instr_o SHALL not change outside FETCH.
REQ-015 Decode inputs SHALL be ignored outside EXEC.
REQ-016 busy_o SHALL be 1 in FETCH and EXEC, and 0 in IDLE and HALT.
REQ-017 imem_req_o and instr_valid_o SHALL be registered state decodes with no combinational path from any input.

Reset
REQ-018 When rst_i=0 at a rising edge, the block SHALL set:
  - state to IDLE;
  - pc_o to RESET_PC;
  - instr_o to 0;
  - error_o to 0;
  - imem_req_o, instr_valid_o and busy_o to 0.
REQ-019 Reset SHALL take priority over every other input in any state, including mid-FETCH with a pending ack. imem_req_o SHALL be 0 in the cycle after the reset edge.
REQ-020 After reset is released, the block SHALL wait in IDLE for start_i and SHALL NOT auto-start.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - Sequential: reset, start_i, instr=32'h0000_0000 with immediate ack, no decode inputs -> pc_o sequence 0, 4, 8; each FETCH plus EXEC is 2 cycles.
  - Jump: pc_o=32'h4000_0010, instr_i=32'h0800_0100, jump_i=1 -> pc_o=32'h4000_0400.
  - Branch backward: pc_o=32'h0000_0020, instr[15:0]=16'hFFFE, branch_i=1, zero_i=1 -> pc_o=32'h0000_001C; the same with zero_i=0 -> 32'h0000_0024.
  - Priority and wrap: jr_i=1, jump_i=1, rs_data_i=32'h0000_0100 -> pc_o=32'h0000_0100. pc_o=32'hFFFF_FFFC with no decode inputs -> pc_o=0.
  - Misaligned jr: jr_i=1, rs_data_i=32'h0000_0102 -> error_o=1, HALT, pc_o unchanged, busy_o=0. start_i is then ignored until reset.
  - Memory stall and reset: ack delayed 3 cycles -> imem_req_o high 4 cycles with pc_o stable. rst_i=0 asserted during FETCH -> next cycle IDLE, imem_req_o=0, pc_o=RESET_PC.
